// File: rtl/load_store_unit_if.sv
// Decode-side request/response and memory-side bus signals of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned N = 64
);
  logic         MemRead;
  logic         MemWrite;
  logic [1:0]   Size;
  logic         SignExt;
  logic [N-1:0] Address;
  logic [N-1:0] WriteData;
  logic [N-1:0] ReadData;
  logic         Busy;
  logic         Done;
  logic [1:0]   FaultCode;
  logic [N-1:0] MemAddr;
  logic [N-1:0] MemWData;
  logic [7:0]   MemWStrb;
  logic         MemReq;
  logic         MemWe;
  logic         MemAck;
  logic [N-1:0] MemRData;

  // LSU side: takes decode requests, masters the memory port
  modport master (
    input  MemRead, MemWrite, Size, SignExt, Address, WriteData, MemAck, MemRData,
    output ReadData, Busy, Done, FaultCode, MemAddr, MemWData, MemWStrb, MemReq, MemWe
  );

  // Environment side: decode stage plus memory
  modport slave (
    output MemRead, MemWrite, Size, SignExt, Address, WriteData, MemAck, MemRData,
    input  ReadData, Busy, Done, FaultCode, MemAddr, MemWData, MemWStrb, MemReq, MemWe
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment check, lane steering, extension
// and an ACCESS timeout; all outputs come straight from flops.
module load_store_unit #(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  load_store_unit_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   alo_q, alo_d;
  logic [1:0]   size_q, size_d;
  logic         sext_q, sext_d;
  logic         we_q, we_d;
  logic [N-1:0] read_data_q, read_data_d;
  logic [1:0]   fault_q, fault_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]   mem_wstrb_q, mem_wstrb_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         misaligned;
  logic [7:0]   size_mask;
  logic [N-1:0] lane;
  logic [N-1:0] ext;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alo_d       = alo_q;
    size_d      = size_q;
    sext_d      = sext_q;
    we_d        = we_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    misaligned  = 1'b0;
    size_mask   = 8'h01;
    lane        = '0;
    ext         = '0;

    // Request-side alignment rule and byte-lane mask for the incoming size
    unique case (bus.Size)
      2'b00:   begin misaligned = 1'b0;               size_mask = 8'h01; end
      2'b01:   begin misaligned = bus.Address[0];     size_mask = 8'h03; end
      2'b10:   begin misaligned = |bus.Address[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |bus.Address[2:0]; size_mask = 8'hFF; end
    endcase

    // Response-side lane extraction and extension for the held request
    lane = bus.MemRData >> {alo_q, 3'b000};
    unique case (size_q)
      2'b00:   ext = sext_q ? {{(N-8){lane[7]}}, lane[7:0]}    : {{(N-8){1'b0}}, lane[7:0]};
      2'b01:   ext = sext_q ? {{(N-16){lane[15]}}, lane[15:0]} : {{(N-16){1'b0}}, lane[15:0]};
      2'b10:   ext = sext_q ? {{(N-32){lane[31]}}, lane[31:0]} : {{(N-32){1'b0}}, lane[31:0]};
      default: ext = lane;
    endcase

    unique case (state_q)
      IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          alo_d  = bus.Address[2:0];
          size_d = bus.Size;
          sext_d = bus.SignExt;
          we_d   = bus.MemWrite;
          if (bus.MemRead && bus.MemWrite) begin
            state_d = FAULT;
            fault_d = 2'b11;
          end else if (misaligned) begin
            state_d = FAULT;
            fault_d = 2'b01;
          end else begin
            state_d     = ACCESS;
            fault_d     = 2'b00;
            cnt_d       = '0;
            mem_addr_d  = {bus.Address[N-1:3], 3'b000};
            mem_wdata_d = bus.WriteData << {bus.Address[2:0], 3'b000};
            mem_wstrb_d = bus.MemWrite ? (size_mask << bus.Address[2:0]) : 8'h00;
          end
        end
      end
      ACCESS: begin
        if (bus.MemAck) begin
          state_d = DONE;
          if (!we_q) read_data_d = ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = FAULT;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status and handshake outputs are registered copies of the next state
    mem_req_d = (state_d == ACCESS);
    mem_we_d  = (state_d == ACCESS) && we_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) || (state_d == FAULT);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alo_q       <= '0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      we_q        <= 1'b0;
      read_data_q <= '0;
      fault_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alo_q       <= alo_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      we_q        <= we_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ReadData  = read_data_q;
  assign bus.FaultCode = fault_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemWData  = mem_wdata_q;
  assign bus.MemWStrb  = mem_wstrb_q;
  assign bus.MemReq    = mem_req_q;
  assign bus.MemWe     = mem_we_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed transactions push expectations,
// a negedge monitor pops them on each MemReq start and each Done pulse.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.N(64)) bus ();

  load_store_unit #(.N(64), .TIMEOUT(16)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic [1:0]  fault;
    logic [63:0] rdata;
    int          nreq;
  } done_t;

  acc_t  acc_exp[$];
  done_t done_exp[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: checks memory-side request fields and every completion pulse
  int          req_cnt  = 0;
  logic        req_prev = 1'b0;
  logic [63:0] f_addr, f_wdata;
  logic [7:0]  f_strb;
  always @(negedge clk) begin
    acc_t  a;
    done_t d;
    if (rst) begin
      req_cnt  = 0;
      req_prev = 1'b0;
    end else begin
      if (bus.MemReq) begin
        if (!req_prev) begin
          if (acc_exp.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_memreq: got MemReq=1 at addr 0x%016h expected none", bus.MemAddr);
          end else begin
            a = acc_exp.pop_front();
            chk("mem_addr", bus.MemAddr, a.addr);
            chk("mem_wstrb", 64'(bus.MemWStrb), 64'(a.strb));
            chk("mem_we", 64'(bus.MemWe), 64'(a.we));
            if (a.strb != 8'h00)
              chk("mem_wdata", bus.MemWData & lane_mask(a.strb), a.wdata & lane_mask(a.strb));
          end
          f_addr  = bus.MemAddr;
          f_strb  = bus.MemWStrb;
          f_wdata = bus.MemWData;
        end else begin
          chk("stable_addr", bus.MemAddr, f_addr);
          chk("stable_strb", 64'(bus.MemWStrb), 64'(f_strb));
          chk("stable_wdata", bus.MemWData, f_wdata);
        end
        req_cnt++;
      end
      req_prev = bus.MemReq;
      if (bus.Done) begin
        if (done_exp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got Done=1 FaultCode=%0b expected no completion", bus.FaultCode);
        end else begin
          d = done_exp.pop_front();
          chk("fault_code", 64'(bus.FaultCode), 64'(d.fault));
          chk("read_data", bus.ReadData, d.rdata);
          chk("memreq_cycles", 64'(req_cnt), 64'(d.nreq));
        end
        req_cnt = 0;
      end
    end
  end

  // Issue one request (called #1 after a rising edge) and play memory for it
  task automatic do_txn(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sx,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdat, input int ack_at,
                        input bit has_acc, input logic [63:0] e_addr,
                        input logic [7:0] e_strb, input logic [63:0] e_wdata,
                        input logic [1:0] e_fault, input logic [63:0] e_rdata,
                        input int e_nreq, input int e_exit);
    int cyc;
    if (has_acc) acc_exp.push_back('{addr: e_addr, strb: e_strb, wdata: e_wdata, we: wr});
    done_exp.push_back('{fault: e_fault, rdata: e_rdata, nreq: e_nreq});
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Size      = sz;
    bus.SignExt   = sx;
    bus.Address   = a;
    bus.WriteData = wd;
    @(posedge clk); #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    cyc = 1;
    while (bus.Busy && cyc < 40) begin
      bus.MemAck   = (cyc == ack_at);
      bus.MemRData = (cyc == ack_at) ? rdat : 64'h0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.MemAck = 1'b0;
    chk({name, "_busy_cycles"}, 64'(cyc), 64'(e_exit));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.MemRead = 0; bus.MemWrite = 0; bus.Size = 0; bus.SignExt = 0;
    bus.Address = 0; bus.WriteData = 0; bus.MemAck = 0; bus.MemRData = 0;

    @(posedge clk); #1;
    chk("rst_busy_during", 64'(bus.Busy), 64'd0);
    chk("rst_memreq_during", 64'(bus.MemReq), 64'd0);
    chk("rst_done_during", 64'(bus.Done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_read_data", bus.ReadData, 64'd0);
    chk("rst_fault", 64'(bus.FaultCode), 64'd0);
    chk("rst_mem_addr", bus.MemAddr, 64'd0);
    chk("rst_mem_wdata", bus.MemWData, 64'd0);
    chk("rst_mem_wstrb", 64'(bus.MemWStrb), 64'd0);
    chk("rst_mem_we", 64'(bus.MemWe), 64'd0);

    //      name         rd wr sz     sx addr          wdata                   rdata                   ack acc exp_addr      strb   exp_wdata               flt    exp_rdata               nreq exit
    do_txn("word_store", 0, 1, 2'b10, 0, 64'h1004, 64'hDEADBEEF,           64'h0,                   3, 1, 64'h1000, 8'hF0, 64'hDEADBEEF_00000000, 2'b00, 64'h0,                   3,  5);
    do_txn("byte_ld_sx", 1, 0, 2'b00, 1, 64'h2003, 64'h0,                  64'h00000000_80000000,  1, 1, 64'h2000, 8'h00, 64'h0,                  2'b00, 64'hFFFFFFFF_FFFFFF80,  1,  3);
    do_txn("byte_ld_zx", 1, 0, 2'b00, 0, 64'h2003, 64'h0,                  64'h00000000_80000000,  1, 1, 64'h2000, 8'h00, 64'h0,                  2'b00, 64'h00000000_00000080,  1,  3);
    do_txn("half_misal", 1, 0, 2'b01, 1, 64'h2001, 64'h0,                  64'h0,                   1, 0, 64'h0,    8'h00, 64'h0,                  2'b01, 64'h00000000_00000080,  0,  2);
    do_txn("timeout",    1, 0, 2'b11, 0, 64'h3000, 64'h0,                  64'h0,                   0, 1, 64'h3000, 8'h00, 64'h0,                  2'b10, 64'h00000000_00000080, 16, 18);
    do_txn("ack_limit",  1, 0, 2'b11, 1, 64'h3008, 64'h0,                  64'h01234567_89ABCDEF, 16, 1, 64'h3008, 8'h00, 64'h0,                  2'b00, 64'h01234567_89ABCDEF, 16, 18);
    do_txn("half_ld_sx", 1, 0, 2'b01, 1, 64'h4006, 64'h0,                  64'h87650000_00000000,  2, 1, 64'h4000, 8'h00, 64'h0,                  2'b00, 64'hFFFFFFFF_FFFF8765,  2,  4);
    do_txn("word_ld_zx", 1, 0, 2'b10, 0, 64'h4004, 64'h0,                  64'hF0000001_00000000,  1, 1, 64'h4000, 8'h00, 64'h0,                  2'b00, 64'h00000000_F0000001,  1,  3);
    do_txn("byte_store", 0, 1, 2'b00, 0, 64'h5005, 64'h11223344_556677AB, 64'h0,                   1, 1, 64'h5000, 8'h20, 64'h0000AB00_00000000, 2'b00, 64'h00000000_F0000001,  1,  3);
    do_txn("dbl_store",  0, 1, 2'b11, 0, 64'h6000, 64'hCAFEBABE_12345678, 64'h0,                   2, 1, 64'h6000, 8'hFF, 64'hCAFEBABE_12345678, 2'b00, 64'h00000000_F0000001,  2,  4);
    do_txn("illegal",    1, 1, 2'b10, 0, 64'h7000, 64'h0,                  64'h0,                   1, 0, 64'h0,    8'h00, 64'h0,                  2'b11, 64'h00000000_F0000001,  0,  2);
    do_txn("word_misal", 0, 1, 2'b10, 0, 64'h7002, 64'h55,                 64'h0,                   1, 0, 64'h0,    8'h00, 64'h0,                  2'b01, 64'h00000000_F0000001,  0,  2);

    // Reset in the second ACCESS cycle abandons the load; a late ack is ignored
    acc_exp.push_back('{addr: 64'h8000, strb: 8'h00, wdata: 64'h0, we: 1'b0});
    bus.MemRead = 1'b1; bus.Size = 2'b10; bus.SignExt = 1'b0; bus.Address = 64'h8000;
    @(posedge clk); #1;
    bus.MemRead = 1'b0;
    chk("rst_txn_req_1st", 64'(bus.MemReq), 64'd1);
    @(posedge clk); #1;
    chk("rst_txn_req_2nd", 64'(bus.MemReq), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort_memreq", 64'(bus.MemReq), 64'd0);
    chk("rst_abort_busy", 64'(bus.Busy), 64'd0);
    chk("rst_abort_done", 64'(bus.Done), 64'd0);
    bus.MemAck = 1'b1; bus.MemRData = 64'hFFFFFFFF_FFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.MemAck = 1'b0;
    chk("late_ack_busy", 64'(bus.Busy), 64'd0);
    chk("late_ack_rdata", bus.ReadData, 64'd0);
    @(posedge clk); #1;

    do_txn("post_rst_ld", 1, 0, 2'b10, 1, 64'h9000, 64'h0,                64'h00000000_7FFFFFFF,  1, 1, 64'h9000, 8'h00, 64'h0,                  2'b00, 64'h00000000_7FFFFFFF,  1,  3);

    repeat (3) @(posedge clk);
    #1;
    chk("acc_queue_drained", 64'(acc_exp.size()), 64'd0);
    chk("done_queue_drained", 64'(done_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
